// File: rtl/blink_rate_ctrl.sv
// blink_rate_ctrl: button conditioning, 4-step rate FSM and tick prescaler
// feeding the LED blink stage.
`timescale 1ns/1ps
module blink_rate_ctrl #(
   parameter int BASE_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   input  logic       en,
   output logic       tick,
   output logic [1:0] rate_sel,
   output logic       press_pulse
);

   localparam int DB_W =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   if (BASE_DIV < 2) begin : g_bad_base
      $error("BASE_DIV must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
      $error("DEBOUNCE_CYCLES must be >= 1");
   end
   if ((CNT_W < 63) &&
       ((longint'(1) << CNT_W) <= longint'(8 * BASE_DIV - 1))) begin : g_bad_w
      $error("CNT_W too narrow for BASE_DIV << 3");
   end

   typedef enum logic [1:0] {
      RATE0 = 2'd0,
      RATE1 = 2'd1,
      RATE2 = 2'd2,
      RATE3 = 2'd3
   } rate_t;

   rate_t            state;
   rate_t            state_nxt;
   logic             sync1;
   logic             btn_s;
   logic             btn_db;
   logic             btn_db_d;
   logic [DB_W-1:0]  db_cnt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div;
   logic [CNT_W-1:0] div_last;

   assign rate_sel = state;
   assign div      = CNT_W'(BASE_DIV) << rate_sel;
   assign div_last = div - CNT_W'(1);

   // two-flop synchronizer for the raw button
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         sync1 <= btn;
         btn_s <= sync1;
      end
   end

   // debounce: accept a level once it differs for DEBOUNCE_CYCLES samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_db      <= 1'b0;
         btn_db_d    <= 1'b0;
         db_cnt      <= '0;
         press_pulse <= 1'b0;
      end else begin
         btn_db_d    <= btn_db;
         press_pulse <= btn_db & ~btn_db_d;
         if (btn_s != btn_db) begin
            if (db_cnt == DB_LAST) begin
               btn_db <= btn_s;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   // rate state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RATE0;
      end else begin
         state <= state_nxt;
      end
   end

   // each accepted press steps to the next rate, wrapping after RATE3
   always_comb begin
      state_nxt = state;
      if (press_pulse) begin
         unique case (state)
            RATE0: state_nxt = RATE1;
            RATE1: state_nxt = RATE2;
            RATE2: state_nxt = RATE3;
            RATE3: state_nxt = RATE0;
         endcase
      end
   end

   // prescaler: a rate change restarts the count and drops any tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (press_pulse) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (en) begin
         if (cnt == div_last) begin
            cnt  <= '0;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: doc/blink_rate_ctrl.md
Name: blink_rate_ctrl

Overview:
- Upstream stage for the LED blink block. It conditions a raw push-button and steps through four blink rates.
- It emits a one-cycle `tick` strobe. The blink stage toggles its LED on each `tick`.
- Internals: 2-flop synchronizer, debounce counter, 4-state rate FSM, programmable prescaler.

Parameters:
- `BASE_DIV`, default 4: tick period in clk cycles at rate 0. Rate n period = `BASE_DIV << n`. Must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a button change. Must be ≥ 1.
- `CNT_W`, default 24: prescaler counter width. Must satisfy `2^CNT_W > 8*BASE_DIV - 1`; elaboration-time check fails otherwise.

Ports:
- `clk` in 1: system clock. All state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `btn` in 1: raw, asynchronous, bouncy push-button. High = pressed.
- `en` in 1: prescaler enable. Synchronous, active-high.
- `tick` out 1: registered one-cycle strobe to the blink stage.
- `rate_sel` out 2: current rate index, 0..3.
- `press_pulse` out 1: registered one-cycle strobe per accepted press.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge): `tick`=0, `press_pulse`=0, `rate_sel`=0, prescaler count=0, sync flops=0, debounced level `btn_db`=0, debounce count=0.
- Synchronizer: `btn` passes through two flops to give `btn_s`. No logic sits between the two flops.
- Debounce:
  - Each cycle where `btn_s` != `btn_db`, the debounce count increments. Any cycle with `btn_s` == `btn_db` clears it to 0.
  - When the count reaches `DEBOUNCE_CYCLES-1` and `btn_s` still differs, `btn_db` takes `btn_s` at that edge and the count clears.
  - `press_pulse` is high for exactly one cycle, in the cycle after `btn_db` goes 0→1. A 1→0 transition produces no pulse.
  - Latency: with `btn` held high from the first sampling edge E, `press_pulse` is high in the cycle starting at edge E+`DEBOUNCE_CYCLES`+2.
- Rate FSM:
  - States RATE0..RATE3, encoded as `rate_sel` 0..3.
  - At the edge ending a `press_pulse` cycle, advance RATE0→1→2→3→0 (wrap on press in RATE3). No other transitions.
  - `rate_sel` is registered and equals the state.
- Prescaler:
  - `DIV` = `BASE_DIV << rate_sel`.
  - When `en`=1: if count == `DIV-1`, count←0 and `tick`←1 for the next cycle; otherwise count←count+1 and `tick`←0.
  - When `en`=0: count holds and `tick`←0.
- Rate change: at the edge where `rate_sel` advances, count←0 and `tick`←0. This overrides a coincident terminal count, so the tick is dropped. The first tick at the new rate is high in the cycle starting `DIV_new` enabled edges later.
- Steady state with `en`=1: `tick` is high for 1 cycle in every `DIV`. The first tick after reset release is high in the cycle starting at the `BASE_DIV`-th edge.
- Simultaneous events:
  - `en`=0 during a rate-change edge still clears the count.
  - A press while the debounce count is nonzero needs no special handling.
  - A button held indefinitely yields a single `press_pulse`.
- Reset mid-operation: all state returns to reset values immediately. After `reset` falls, behaviour is identical to power-up.
- No combinational path from any input to any output.

Test Plan (`BASE_DIV`=4, `DEBOUNCE_CYCLES`=4, 2 ns clk period):
- Release reset, `en`=1, `btn`=0 for 40 cycles → `rate_sel`=0; `tick` high 1 cycle every 4 cycles (10 ticks); `press_pulse` never high.
- `btn` high for 3 cycles, then low; repeat 5 glitches spaced 2 cycles apart → no `press_pulse`; `rate_sel` stays 0; tick period stays 4.
- `btn` held high 30 cycles from edge E, then low 30 cycles:
  - exactly one `press_pulse`, in the cycle starting at E+6;
  - `rate_sel`=1 from the next edge;
  - ticks every 8 cycles, first one 8 cycles after the change;
  - no pulse on release.
- Four clean presses, each held 10 cycles and separated by 20 → `rate_sel` sequence 1,2,3,0; measured tick periods 8,16,32,4.
- `en`=0 for 10 cycles mid-count, with count=2 at rate 0 → no ticks while low. After `en` returns, the next tick is high in the cycle starting at the 2nd enabled edge.
- At rate 2 with count=9, assert `reset` between clock edges → `tick`, `press_pulse`, `rate_sel` are 0 before the next edge. After release, ticks every 4 cycles.
